mem_lsu: RTL and testbench

Load/store initiator between the core's execute stage and the physical-memory responder. Accepts one RISC-V load or store per handshake, drives a word-aligned memory request with byte mask and lane-shifted write data, and waits for the memory response. Loaded data is then extracted and sign- or zero-extended before being returned to the core. Only one transaction is outstanding at a time, and the block enforces alignment and a response timeout.

---
 rtl/lsu_pkg.sv | 77 +++++++
 rtl/lsu_fmt.sv | 26 ++
 rtl/mem_lsu.sv | 159 +++++++++++++++
 tb/tb_mem_lsu.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg : shared state encoding, funct3 sizes and load/store lane helpers
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lsu_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  // Returns {byte_mask[3:0], lane_data[31:0]}; unsupported sizes give all zero.
  function automatic logic [35:0] fmt_store(input logic [2:0]  size,
                                            input logic [1:0]  off,
                                            input logic [31:0] data);
    logic [3:0]  mask;
    logic [31:0] wd;
    mask = 4'b0000;
    wd   = 32'h0;
    case (size)
      SZ_B: begin
        mask = 4'b0001 << off;
        wd   = {4{data[7:0]}};
      end
      SZ_H: begin
        mask = 4'b0011 << off;
        wd   = {2{data[15:0]}};
      end
      SZ_W: begin
        mask = 4'b1111;
        wd   = data;
      end
      default: ;
    endcase
    return {mask, wd};
  endfunction

  function automatic logic [31:0] ext_load(input logic [2:0]  size,
                                           input logic [1:0]  off,
                                           input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      SZ_B:    return {{24{sh[7]}}, sh[7:0]};
      SZ_H:    return {{16{sh[15]}}, sh[15:0]};
      SZ_W:    return word;
      SZ_BU:   return {24'h0, sh[7:0]};
      SZ_HU:   return {16'h0, sh[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  // Unsigned sizes exist only for loads; halves and words must be naturally aligned.
  function automatic logic req_legal(input logic       wen,
                                     input logic [2:0] size,
                                     input logic [1:0] off);
    case (size)
      SZ_B:    return 1'b1;
      SZ_H:    return ~off[0];
      SZ_W:    return (off == 2'b00);
      SZ_BU:   return ~wen;
      SZ_HU:   return ~wen & ~off[0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_fmt.sv
// ---------------------------------------------------------------------------
// lsu_fmt : combinational store lane formatter and load extractor
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lsu_fmt
  import lsu_pkg::*;
(
  input  logic [2:0]  st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  input  logic [2:0]  ld_size_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_word_i,
  output logic [3:0]  st_mask_o,
  output logic [31:0] st_wdata_o,
  output logic [31:0] ld_data_o
);

  assign {st_mask_o, st_wdata_o} = fmt_store(st_size_i, st_off_i, st_data_i);
  assign ld_data_o               = ext_load(ld_size_i, ld_off_i, ld_word_i);

endmodule

`default_nettype wire

// File: rtl/mem_lsu.sv
// ---------------------------------------------------------------------------
// mem_lsu : single-outstanding RISC-V load/store initiator with response timeout
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wen_i,
  input  logic [2:0]  req_size_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        mem_valid_o,
  input  logic        mem_ready_i,
  output logic        mem_wen_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [7:0]  mem_wmask_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  logic [1:0]       state_q, state_d;
  logic             wen_q, wen_d;
  logic [2:0]       size_q, size_d;
  logic [1:0]       off_q, off_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wmask_q, wmask_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic [3:0]       st_mask;
  logic [31:0]      st_wdata;
  logic [31:0]      ld_data;

  lsu_fmt u_fmt (
    .st_size_i  (req_size_i),
    .st_off_i   (req_addr_i[1:0]),
    .st_data_i  (req_wdata_i),
    .ld_size_i  (size_q),
    .ld_off_i   (off_q),
    .ld_word_i  (mem_rdata_i),
    .st_mask_o  (st_mask),
    .st_wdata_o (st_wdata),
    .ld_data_o  (ld_data)
  );

  always_comb begin
    state_d = state_q;
    wen_d   = wen_q;
    size_d  = size_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          wen_d   = req_wen_i;
          size_d  = req_size_i;
          off_d   = req_addr_i[1:0];
          addr_d  = {req_addr_i[31:2], 2'b00};
          wdata_d = req_wen_i ? st_wdata : 32'h0;
          wmask_d = req_wen_i ? st_mask : 4'b0000;
          rdata_d = 32'h0;
          // Illegal requests skip memory entirely and answer with an error.
          if (req_legal(req_wen_i, req_size_i, req_addr_i[1:0])) begin
            err_d   = 1'b0;
            state_d = ST_REQ;
          end else begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_REQ: begin
        if (mem_ready_i) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid_i) begin
          err_d   = 1'b0;
          rdata_d = wen_q ? 32'h0 : ld_data;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_MAX) begin
          err_d   = 1'b1;
          rdata_d = 32'h0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (resp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      wen_q   <= 1'b0;
      size_q  <= 3'b000;
      off_q   <= 2'b00;
      cnt_q   <= '0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wmask_q <= 4'b0000;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wen_q   <= wen_d;
      size_q  <= size_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o  = (state_q == ST_IDLE);
  assign resp_valid_o = (state_q == ST_RESP);
  assign mem_valid_o  = (state_q == ST_REQ);
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;
  assign mem_wen_o    = wen_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign mem_wmask_o  = {4'b0000, wmask_q};

endmodule

`default_nettype wire

// File: tb/tb_mem_lsu.sv
// ---------------------------------------------------------------------------
// tb_mem_lsu : scoreboard bench for mem_lsu (TIMEOUT overridden to 4)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [2:0]  req_size = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  always #5 clk = ~clk;

  mem_lsu #(.TIMEOUT(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_wen_i    (req_wen),
    .req_size_i   (req_size),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_rdata_o (resp_rdata),
    .resp_err_o   (resp_err),
    .mem_valid_o  (mem_valid),
    .mem_ready_i  (mem_ready),
    .mem_wen_o    (mem_wen),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_wmask_o  (mem_wmask),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Observations captured by run_txn for the calling test to judge.
  int          o_lat;
  int          o_memv;
  logic [31:0] o_rdata, o_addr, o_wdata;
  logic        o_err, o_wen;
  logic [7:0]  o_mask;
  bit          o_unstable, o_hold_bad;

  function automatic logic [31:0] model_load(input logic [2:0] size, input logic [1:0] off,
                                             input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (size)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return w;
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return 32'h0;
    endcase
  endfunction

  // Issue one request and play the memory side; rv_wait < 0 means never respond.
  task automatic run_txn(input logic wen, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] word,
                         input int rdy_wait, input int rv_wait, input int rr_wait);
    int mv = 0;
    int wc = 0;
    bit in_wait = 0;
    bit done = 0;
    o_lat = -1; o_memv = 0; o_unstable = 0; o_hold_bad = 0;
    o_rdata = 32'hx; o_err = 1'bx;
    o_addr = 32'h0; o_wdata = 32'h0; o_mask = 8'h0; o_wen = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_wen = wen; req_size = size; req_addr = addr; req_wdata = wdata;
    mem_rdata = word;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rvalid = 1'b0;
      if (resp_valid) begin
        o_lat = cyc; o_rdata = resp_rdata; o_err = resp_err;
        for (int h = 0; h < rr_wait; h++) begin
          resp_ready = 1'b0;
          @(negedge clk);
          if (!resp_valid || resp_rdata !== o_rdata || resp_err !== o_err || req_ready !== 1'b0)
            o_hold_bad = 1;
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        done = 1;
      end else if (mem_valid) begin
        if (mv == 0) begin
          o_addr = mem_addr; o_wdata = mem_wdata; o_mask = mem_wmask; o_wen = mem_wen;
        end else if (mem_addr !== o_addr || mem_wdata !== o_wdata || mem_wmask !== o_mask) begin
          o_unstable = 1;
        end
        mv++;
        if (mv > rdy_wait) begin
          mem_ready = 1'b1;
          in_wait = 1;
        end
      end else if (in_wait) begin
        if (rv_wait >= 0 && wc == rv_wait) mem_rvalid = 1'b1;
        wc++;
      end
    end
    o_memv = mv;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_err, mem_valid, mem_wen} !== 5'b10000 ||
        {mem_addr, mem_wdata, resp_rdata, mem_wmask} !== 104'h0) begin
      errors++;
      $display("FAIL reset_values: ctl=%b data=%h/%h/%h/%h required ctl=10000 data all zero",
               {req_ready, resp_valid, resp_err, mem_valid, mem_wen},
               mem_addr, mem_wdata, resp_rdata, mem_wmask);
    end
    rst = 1'b0;
  endtask

  task automatic test_load;
    exp_t e;
    sb.push_back('{32'hFFFFFF88, 1'b0});
    run_txn(1'b0, 3'b000, 32'h80000003, 32'h0, 32'h8899AABB, 0, 0, 0);
    e = sb.pop_front();
    checks++;
    if (o_rdata !== e.rdata || o_err !== e.err) begin
      errors++;
      $display("FAIL lb_sign: got %h/%b required %h/%b", o_rdata, o_err, e.rdata, e.err);
    end
    checks++;
    if (o_lat !== 3) begin
      errors++;
      $display("FAIL min_latency: got %0d required 3", o_lat);
    end
    checks++;
    if (o_addr !== 32'h80000000 || o_wen !== 1'b0) begin
      errors++;
      $display("FAIL load_req: addr %h wen %b required 80000000 0", o_addr, o_wen);
    end
    sb.push_back('{32'h00000088, 1'b0});
    run_txn(1'b0, 3'b100, 32'h80000003, 32'h0, 32'h8899AABB, 0, 0, 0);
    e = sb.pop_front();
    checks++;
    if (o_rdata !== e.rdata || o_err !== e.err) begin
      errors++;
      $display("FAIL lbu_zero: got %h/%b required %h/%b", o_rdata, o_err, e.rdata, e.err);
    end
  endtask

  task automatic test_load_sweep;
    logic [2:0] sizes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    exp_t e;
    logic [31:0] w;
    for (int s = 0; s < 5; s++) begin
      for (int off = 0; off < 4; off++) begin
        if ((sizes[s][1:0] == 2'b01 && off[0]) || (sizes[s][1:0] == 2'b10 && off != 0)) continue;
        w = $urandom;
        sb.push_back('{model_load(sizes[s], off[1:0], w), 1'b0});
        run_txn(1'b0, sizes[s], 32'h20000000 + 32'(s * 16 + off), 32'h0, w,
                $urandom_range(0, 2), $urandom_range(0, 2), 0);
        e = sb.pop_front();
        checks++;
        if (o_rdata !== e.rdata || o_err !== e.err) begin
          errors++;
          $display("FAIL load_sweep size=%b off=%0d word=%h: got %h/%b required %h/%b",
                   sizes[s], off, w, o_rdata, o_err, e.rdata, e.err);
        end
      end
    end
  endtask

  task automatic test_store;
    exp_t e;
    sb.push_back('{32'h0, 1'b0});
    run_txn(1'b1, 3'b001, 32'h80000002, 32'h00001234, 32'hDEADBEEF, 0, 0, 0);
    e = sb.pop_front();
    checks++;
    if (o_mask !== 8'b00001100 || o_wdata !== 32'h12341234 || o_addr !== 32'h80000000 ||
        o_wen !== 1'b1) begin
      errors++;
      $display("FAIL sh_format: mask %b wdata %h addr %h wen %b required 00001100 12341234 80000000 1",
               o_mask, o_wdata, o_addr, o_wen);
    end
    checks++;
    if (o_rdata !== e.rdata || o_err !== e.err) begin
      errors++;
      $display("FAIL sh_resp: got %h/%b required %h/%b", o_rdata, o_err, e.rdata, e.err);
    end
    for (int off = 0; off < 4; off++) begin
      sb.push_back('{32'h0, 1'b0});
      run_txn(1'b1, 3'b000, 32'h00000040 + 32'(off), 32'h000000A5, 32'h0, 0, 1, 0);
      e = sb.pop_front();
      checks++;
      if (o_mask !== (8'h01 << off) || o_wdata !== 32'hA5A5A5A5 || o_rdata !== e.rdata ||
          o_err !== e.err) begin
        errors++;
        $display("FAIL sb_off%0d: mask %b wdata %h resp %h/%b required %b A5A5A5A5 %h/%b",
                 off, o_mask, o_wdata, o_rdata, o_err, 8'h01 << off, e.rdata, e.err);
      end
    end
    sb.push_back('{32'h0, 1'b0});
    run_txn(1'b1, 3'b010, 32'h00000010, 32'hCAFEF00D, 32'h0, 0, 0, 0);
    e = sb.pop_front();
    checks++;
    if (o_mask !== 8'b00001111 || o_wdata !== 32'hCAFEF00D || o_err !== e.err) begin
      errors++;
      $display("FAIL sw_format: mask %b wdata %h err %b required 00001111 CAFEF00D %b",
               o_mask, o_wdata, o_err, e.err);
    end
  endtask

  task automatic test_errors;
    logic        t_wen  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0]  t_size [5] = '{3'b010, 3'b001, 3'b100, 3'b011, 3'b101};
    logic [31:0] t_addr [5] = '{32'h80000001, 32'h00000003, 32'h0, 32'h0, 32'h00000001};
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      sb.push_back('{32'h0, 1'b1});
      run_txn(t_wen[i], t_size[i], t_addr[i], 32'hFFFFFFFF, 32'h12345678, 0, 0, 0);
      e = sb.pop_front();
      checks++;
      if (o_rdata !== e.rdata || o_err !== e.err || o_lat !== 1 || o_memv !== 0) begin
        errors++;
        $display("FAIL err_case%0d: resp %h/%b lat %0d memv %0d required %h/%b lat 1 memv 0",
                 i, o_rdata, o_err, o_lat, o_memv, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_req_stall;
    exp_t e;
    sb.push_back('{32'h0000BEEF, 1'b0});
    run_txn(1'b0, 3'b101, 32'h00000302, 32'h0, 32'hBEEF0000, 3, 0, 0);
    e = sb.pop_front();
    checks++;
    if (o_memv !== 4 || o_unstable !== 1'b0 || o_lat !== 6) begin
      errors++;
      $display("FAIL req_stall: memv %0d unstable %b lat %0d required 4 0 6",
               o_memv, o_unstable, o_lat);
    end
    checks++;
    if (o_rdata !== e.rdata || o_err !== e.err) begin
      errors++;
      $display("FAIL req_stall_data: got %h/%b required %h/%b", o_rdata, o_err, e.rdata, e.err);
    end
  endtask

  task automatic test_timeout;
    exp_t e;
    sb.push_back('{32'h0, 1'b1});
    run_txn(1'b0, 3'b010, 32'h00000100, 32'h0, 32'h55555555, 0, -1, 0);
    e = sb.pop_front();
    checks++;
    if (o_rdata !== e.rdata || o_err !== e.err || o_lat !== 7) begin
      errors++;
      $display("FAIL timeout: resp %h/%b lat %0d required %h/%b lat 7",
               o_rdata, o_err, o_lat, e.rdata, e.err);
    end
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL stale_idle: resp_valid %b req_ready %b mem_valid %b required 0 1 0",
               resp_valid, req_ready, mem_valid);
    end
    sb.push_back('{32'h600DF00D, 1'b0});
    run_txn(1'b0, 3'b010, 32'h00000104, 32'h0, 32'h600DF00D, 0, 3, 0);
    e = sb.pop_front();
    checks++;
    if (o_rdata !== e.rdata || o_err !== e.err) begin
      errors++;
      $display("FAIL after_timeout: got %h/%b required %h/%b", o_rdata, o_err, e.rdata, e.err);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    sb.push_back('{32'hFFFF8001, 1'b0});
    run_txn(1'b0, 3'b001, 32'h00000200, 32'h0, 32'h12348001, 0, 0, 2);
    e = sb.pop_front();
    checks++;
    if (o_hold_bad !== 1'b0 || o_rdata !== e.rdata || o_err !== e.err) begin
      errors++;
      $display("FAIL resp_hold: hold_bad %b resp %h/%b required 0 %h/%b",
               o_hold_bad, o_rdata, o_err, e.rdata, e.err);
    end
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready: req_ready %b resp_valid %b required 1 0", req_ready, resp_valid);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b1; req_size = 3'b010; req_addr = 32'h00000400;
    req_wdata = 32'h11223344;
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (mem_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_req: mem_valid %b required 1", mem_valid);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({req_ready, resp_valid, resp_err, mem_valid, mem_wen} !== 5'b10000 ||
        {mem_addr, mem_wdata, resp_rdata, mem_wmask} !== 104'h0) begin
      errors++;
      $display("FAIL reset_in_wait: ctl=%b data=%h/%h/%h/%h required ctl=10000 data all zero",
               {req_ready, resp_valid, resp_err, mem_valid, mem_wen},
               mem_addr, mem_wdata, resp_rdata, mem_wmask);
    end
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL stale_after_reset: resp_valid %b req_ready %b required 0 1",
               resp_valid, req_ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_load_sweep();
    test_store();
    test_errors();
    test_req_stall();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
